dual_voice_pwm_mixer: RTL and testbench

//  Downstream of the two-channel note sequencer: consumes its two 1-bit square-wave

---
 rtl/dual_voice_pwm_mixer.sv | 132 +++++++++++++
 tb/tb_dual_voice_pwm_mixer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_voice_pwm_mixer.sv
// dual_voice_pwm_mixer
//   Takes the two 1-bit square waves from the note sequencer and detects note
//   starts and silence on each voice. It applies a decaying amplitude envelope to
//   each voice and mixes both into one PWM stream for the buzzer. The PWM period
//   is 256 clocks with an 8-bit duty.
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   ch_in0   voice 0 square wave (unsynchronised)
//   ch_in1   voice 1 square wave (unsynchronised)
//   pwm_out  mixed PWM output to the buzzer pin
//   active0  voice 0 currently sounding
//   active1  voice 1 currently sounding
//   duty     duty value of the current PWM period (debug)
module dual_voice_pwm_mixer #(
  parameter int unsigned SILENCE_CYC = 30000,
  parameter int unsigned DECAY_CYC   = 12000,
  parameter int unsigned AMP_MAX     = 255,
  parameter int unsigned AMP_SUSTAIN = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_in0,
  input  logic       ch_in1,
  output logic       pwm_out,
  output logic       active0,
  output logic       active1,
  output logic [7:0] duty
);

  localparam int unsigned SCW = $clog2(SILENCE_CYC + 1);
  localparam int unsigned DCW = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;

  localparam logic [SCW-1:0] SC_MAX  = SCW'(SILENCE_CYC);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DECAY_CYC - 1);
  localparam logic [7:0]     AMP_TOP = 8'(AMP_MAX);
  localparam logic [7:0]     AMP_SUS = 8'(AMP_SUSTAIN);

  logic [1:0]     ch;
  logic [1:0]     meta_q, s_q, s_dly_q;
  logic [1:0]     act_q, act_d;
  logic [SCW-1:0] sc_q   [2];
  logic [SCW-1:0] sc_d   [2];
  logic [7:0]     amp_q  [2];
  logic [7:0]     amp_d  [2];
  logic [DCW-1:0] dcnt_q [2];
  logic [DCW-1:0] dcnt_d [2];

  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] duty_q, duty_d;
  logic       pwm_q, pwm_d;
  logic [8:0] sum;

  assign ch = {ch_in1, ch_in0};

  // Per-voice silence detection and envelope
  always_comb begin
    act_d = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      logic edge_k, note_on, tick;
      edge_k    = s_q[k] ^ s_dly_q[k];
      note_on   = edge_k && (sc_q[k] == SC_MAX);
      tick      = (dcnt_q[k] == DC_LAST);
      sc_d[k]   = sc_q[k];
      amp_d[k]  = amp_q[k];
      dcnt_d[k] = dcnt_q[k];

      if (edge_k)               sc_d[k] = '0;
      else if (sc_q[k] < SC_MAX) sc_d[k] = sc_q[k] + 1'b1;
      act_d[k] = (sc_d[k] < SC_MAX);

      // A note-on restarts the decay phase, so a tick that falls in the same cycle is dropped
      if (note_on) begin
        amp_d[k]  = AMP_TOP;
        dcnt_d[k] = '0;
      end else begin
        dcnt_d[k] = tick ? '0 : dcnt_q[k] + 1'b1;
        if (tick) begin
          if (act_q[k] && (amp_q[k] > AMP_SUS))
            amp_d[k] = amp_q[k] - 8'd1;
          else if (!act_q[k] && (amp_q[k] != 8'd0))
            amp_d[k] = amp_q[k] - 8'd1;
        end
      end
    end
  end

  // Mixer and PWM
  always_comb begin
    sum       = {1'b0, (s_q[0] ? amp_q[0] : 8'd0)} + {1'b0, (s_q[1] ? amp_q[1] : 8'd0)};
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    duty_d    = (pwm_cnt_q == 8'hFF) ? 8'(sum >> 1) : duty_q;
    // Registered compare against next-state values keeps pwm_q aligned with pwm_cnt_q
    pwm_d     = (pwm_cnt_d < duty_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= '0;
      s_q       <= '0;
      s_dly_q   <= '0;
      act_q     <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        sc_q[k]   <= SC_MAX;
        amp_q[k]  <= '0;
        dcnt_q[k] <= '0;
      end
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      meta_q    <= ch;
      s_q       <= meta_q;
      s_dly_q   <= s_q;
      act_q     <= act_d;
      for (int unsigned k = 0; k < 2; k++) begin
        sc_q[k]   <= sc_d[k];
        amp_q[k]  <= amp_d[k];
        dcnt_q[k] <= dcnt_d[k];
      end
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign active0 = act_q[0];
  assign active1 = act_q[1];
  assign duty    = duty_q;

endmodule

// File: tb/tb_dual_voice_pwm_mixer.sv
// Testbench for dual_voice_pwm_mixer.
//   A reference model steps once per clock and queues the expected outputs.
//   A monitor pops one entry per cycle and compares it with the DUT outputs.
//   Directed checks cover asynchronous reset and a full-period PWM high count.
module tb_dual_voice_pwm_mixer;

  localparam int SIL  = 16;
  localparam int DEC  = 4;
  localparam int AMX  = 200;
  localparam int ASUS = 190;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch_in0 = 1'b0;
  logic       ch_in1 = 1'b0;
  logic       pwm_out, active0, active1;
  logic [7:0] duty;

  dual_voice_pwm_mixer #(
    .SILENCE_CYC(SIL),
    .DECAY_CYC  (DEC),
    .AMP_MAX    (AMX),
    .AMP_SUSTAIN(ASUS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_in0 (ch_in0),
    .ch_in1 (ch_in1),
    .pwm_out(pwm_out),
    .active0(active0),
    .active1(active1),
    .duty   (duty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pwm;
    logic       a0;
    logic       a1;
    logic [7:0] duty;
  } obs_t;

  obs_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state. A voice is heard two samples late, and an edge is a
  // change between consecutive heard samples.
  int m_hist [2][3];
  int m_since[2];
  int m_amp  [2];
  int m_ph   [2];
  bit m_act  [2];
  int m_cnt, m_duty;
  bit m_pwm;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
      m_since[k] = SIL;
      m_amp[k]   = 0;
      m_ph[k]    = 0;
      m_act[k]   = 1'b0;
    end
    m_cnt  = 0;
    m_duty = 0;
    m_pwm  = 1'b0;
  endtask

  task automatic model_step(input bit x0, input bit x1);
    int sum;
    bit x[2];
    bit ev, note_on, tick, sounding;
    x[0] = x0;
    x[1] = x1;
    sum  = 0;
    for (int k = 0; k < 2; k++) begin
      ev       = (m_hist[k][1] != m_hist[k][2]);
      sounding = (m_since[k] < SIL);
      if (m_hist[k][1] != 0) sum += m_amp[k];
      note_on = ev && (m_since[k] == SIL);
      tick    = (m_ph[k] == DEC - 1);
      if (note_on) begin
        m_amp[k] = AMX;
        m_ph[k]  = 0;
      end else begin
        if (tick) begin
          if (sounding && m_amp[k] > ASUS)  m_amp[k]--;
          else if (!sounding && m_amp[k] > 0) m_amp[k]--;
        end
        m_ph[k] = (m_ph[k] + 1) % DEC;
      end
      m_since[k] = ev ? 0 : ((m_since[k] < SIL) ? m_since[k] + 1 : SIL);
      m_act[k]   = (m_since[k] < SIL);
      m_hist[k][2] = m_hist[k][1];
      m_hist[k][1] = m_hist[k][0];
      m_hist[k][0] = int'(x[k]);
    end
    if (m_cnt == 255) m_duty = sum / 2;
    m_cnt = (m_cnt + 1) % 256;
    m_pwm = (m_cnt < m_duty);
  endtask

  task automatic model_proc();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(ch_in0, ch_in1);
      expq.push_back({m_pwm, m_act[0], m_act[1], 8'(m_duty)});
    end
  endtask

  task automatic monitor_proc();
    obs_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_cmp++;
        if ({pwm_out, active0, active1, duty} !== e) begin
          n_bad++;
          $display("FAIL cycle_check t=%0t: got pwm=%b a0=%b a1=%b duty=%0d, want pwm=%b a0=%b a1=%b duty=%0d",
                   $time, pwm_out, active0, active1, duty, e.pwm, e.a0, e.a1, e.duty);
        end
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Inputs change 2 time units after the falling edge, away from both edges
  task automatic step_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic toggle_run(input bit en0, input bit en1, input int period, input int len);
    for (int i = 0; i < len; i++) begin
      step_cyc();
      if ((i % period) == 0) begin
        if (en0) ch_in0 = ~ch_in0;
        if (en1) ch_in1 = ~ch_in1;
      end
    end
  endtask

  task automatic wait_cnt(input int target, input string name);
    int n;
    n = 0;
    while (m_cnt != target && n < 300) begin
      step_cyc();
      n++;
    end
    if (m_cnt != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: pwm phase %0d not reached, at %0d", name, target, m_cnt);
    end
  endtask

  initial begin
    int highs;
    int len, md0, md1, p0, p1;
    model_reset();
    fork
      model_proc();
      monitor_proc();
    join_none

    // Reset held with toggling inputs, then the first edge must give a note-on
    toggle_run(1'b1, 1'b1, 1, 5);
    step_cyc();
    rst = 1'b0;
    repeat (20) step_cyc();

    // Voice 0 note-on and decay to sustain
    toggle_run(1'b1, 1'b0, 2, 60);

    // Silence, then full decay to zero, then a fresh note
    repeat (900) step_cyc();
    toggle_run(1'b1, 1'b0, 2, 30);
    repeat (40) step_cyc();

    // Both voices sustained and held high across a period boundary
    toggle_run(1'b1, 1'b1, 2, 60);
    for (int n = 0; n < 300 && m_cnt != 240; n++) begin
      step_cyc();
      ch_in0 = ~ch_in0;
      ch_in1 = ch_in0;
    end
    ch_in0 = 1'b1;
    ch_in1 = 1'b1;
    wait_cnt(0, "period_start");
    check("duty_both_sustain", int'(duty), ASUS);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) step_cyc();
      if (pwm_out) highs++;
    end
    check("pwm_high_count", highs, ASUS);

    // Note-on placed at every decay phase so one lands on a tick
    for (int off = 0; off < 8; off++) begin
      repeat (60) step_cyc();
      repeat (off) step_cyc();
      ch_in0 = ~ch_in0;
      ch_in1 = 1'b1;
      repeat (30) step_cyc();
    end

    // Randomised segments: silence (held at a random level) or toggling
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(20, 400);
      md0 = $urandom_range(0, 2);
      md1 = $urandom_range(0, 2);
      p0  = $urandom_range(1, 6);
      p1  = $urandom_range(1, 6);
      if (md0 == 0) ch_in0 = 1'($urandom_range(0, 1));
      if (md1 == 0) ch_in1 = 1'($urandom_range(0, 1));
      toggle_run(md0 != 0, md1 != 0, (md0 != 0) ? p0 : p1, len);
    end

    // Reset asserted mid-note clears outputs immediately
    toggle_run(1'b1, 1'b1, 2, 80);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_act", int'({active0, active1}), 0);
    check("async_reset_duty", int'(duty), 0);
    repeat (3) step_cyc();
    rst = 1'b0;
    toggle_run(1'b1, 1'b0, 3, 300);
    repeat (5) step_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
